// File: rtl/sync_signal_pulse.sv
// -----------------------------------------------------------------------------
// sync_signal_pulse
//
// Input conditioner for one asynchronous 1-bit control strobe entering the clk
// domain (from a pad or another clock domain). The strobe passes through a
// SYNC_STAGES-deep flop synchronizer and then an optional glitch filter that
// needs FILTER_LEN consecutive identical synchronized samples before the
// conditioned level may change. Registered one-cycle pulses mark each rising
// and falling edge of the conditioned level.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops, 2..4
//   FILTER_LEN   consecutive samples needed to change level, 1..16 (1 = off)
//
// Ports:
//   clk           single clock, all state updates on its rising edge
//   rst_n         synchronous active-low reset, priority over all updates
//   signal_in     asynchronous input, no timing relation to clk
//   signal_level  synchronized, filtered level of signal_in
//   signal_out    one-cycle pulse in the first cycle signal_level reads 1
//   fall_out      one-cycle pulse in the first cycle signal_level reads 0
//
// Latency: an input first sampled high at edge k shows up on signal_level and
// signal_out after edge k + SYNC_STAGES + FILTER_LEN - 1; falls match.
// -----------------------------------------------------------------------------
module sync_signal_pulse #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signal_in,
    output logic signal_level,
    output logic signal_out,
    output logic fall_out
);

    // Counter holds 0..FILTER_LEN-1; at least one bit so FILTER_LEN=1 stays legal.
    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    // Elaboration-time guard on the legal parameter ranges.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
            $error("sync_signal_pulse: SYNC_STAGES must be in 2..4");
        end
        if (FILTER_LEN < 1 || FILTER_LEN > 16) begin : gen_bad_filter_len
            $error("sync_signal_pulse: FILTER_LEN must be in 1..16");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CntW-1:0]        cnt_q;
    logic [CntW-1:0]        cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    // Synchronized sample; the only synchronizer bit that leaves the chain.
    logic s;

    // -------------------------------------------------------------------------
    // Synchronizer chain
    // -------------------------------------------------------------------------
    // sync_q[0] may go metastable; only sync_q[1] ever reads it.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Glitch filter
    // -------------------------------------------------------------------------
    // The counter tracks how many consecutive samples have disagreed with the
    // current level. Any agreeing sample restarts the count, so a level change
    // needs FILTER_LEN disagreeing samples in a row.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Edge pulses
    // -------------------------------------------------------------------------
    // Pulses are registered alongside the level, so they coincide with the
    // first cycle of the new level and are mutually exclusive by construction.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign signal_level = level_q;
    assign signal_out   = rise_q;
    assign fall_out     = fall_q;

endmodule

// File: tb/tb_sync_signal_pulse.sv
// -----------------------------------------------------------------------------
// tb_sync_signal_pulse
//
// Drives three differently parameterised conditioners from one shared input
// and reset, and compares every cycle against a sample-history reference:
// the synchronized value is the input as sampled SYNC_STAGES edges earlier,
// and the level flips once the last FILTER_LEN such samples all disagree
// with it. Directed phases follow the test plan, then random stimulus.
// -----------------------------------------------------------------------------
module tb_sync_signal_pulse;

    localparam int NDut = 3;
    localparam int SS[NDut] = '{2, 2, 3};
    localparam int FL[NDut] = '{1, 3, 5};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signal_in = 1'b0;
    logic [NDut-1:0] lvl;
    logic [NDut-1:0] rise;
    logic [NDut-1:0] fall;

    always #5 clk = ~clk;

    sync_signal_pulse #(.SYNC_STAGES(2), .FILTER_LEN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
        .signal_level(lvl[0]), .signal_out(rise[0]), .fall_out(fall[0])
    );
    sync_signal_pulse #(.SYNC_STAGES(2), .FILTER_LEN(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
        .signal_level(lvl[1]), .signal_out(rise[1]), .fall_out(fall[1])
    );
    sync_signal_pulse #(.SYNC_STAGES(3), .FILTER_LEN(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in),
        .signal_level(lvl[2]), .signal_out(rise[2]), .fall_out(fall[2])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int rise_cnt[NDut];
    int fall_cnt[NDut];
    int rise_cyc[NDut][$];

    // Reference model state.
    bit in_hist[$];          // in_hist[0] = most recently sampled input
    bit win[NDut][$];        // recent synchronized samples per instance
    bit m_level[NDut];
    bit m_rise[NDut];
    bit m_fall[NDut];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_edge(input bit rst, input bit din);
        if (!rst) begin
            in_hist = {};
            for (int i = 0; i < 4; i++) in_hist.push_back(1'b0);
            for (int i = 0; i < NDut; i++) begin
                win[i]     = {};
                m_level[i] = 1'b0;
                m_rise[i]  = 1'b0;
                m_fall[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < NDut; i++) begin
                bit s;
                bit nxt;
                bit all_differ;
                s   = in_hist[SS[i]-1];
                nxt = m_level[i];
                win[i].push_back(s);
                if (win[i].size() > FL[i]) void'(win[i].pop_front());
                if (win[i].size() == FL[i]) begin
                    all_differ = 1'b1;
                    for (int j = 0; j < win[i].size(); j++)
                        if (win[i][j] == m_level[i]) all_differ = 1'b0;
                    if (all_differ) nxt = ~m_level[i];
                end
                m_rise[i]  = nxt & ~m_level[i];
                m_fall[i]  = ~nxt & m_level[i];
                m_level[i] = nxt;
            end
            in_hist.push_front(din);
            void'(in_hist.pop_back());
        end
    endtask

    // One clock: apply inputs, let the edge happen, update model, compare.
    task automatic cycle(input bit rst, input bit din);
        rst_n     = rst;
        signal_in = din;
        @(posedge clk);
        model_edge(rst, din);
        #1;
        cyc++;
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("level%0d", i), {31'b0, lvl[i]}, {31'b0, m_level[i]});
            check($sformatf("rise%0d", i), {31'b0, rise[i]}, {31'b0, m_rise[i]});
            check($sformatf("fall%0d", i), {31'b0, fall[i]}, {31'b0, m_fall[i]});
            if (rise[i] === 1'b1) begin
                rise_cnt[i]++;
                rise_cyc[i].push_back(cyc);
            end
            if (fall[i] === 1'b1) fall_cnt[i]++;
        end
    endtask

    task automatic run(input bit rst, input bit din, input int n);
        for (int k = 0; k < n; k++) cycle(rst, din);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NDut; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
            rise_cyc[i] = {};
        end
    endtask

    initial begin
        int gap;
        bit din;
        model_edge(1'b0, 1'b0);

        // Reset, then a 2-cycle pulse after 10 idle cycles.
        run(1'b0, 1'b0, 3);
        clr_cnt();
        run(1'b1, 1'b0, 10);
        run(1'b1, 1'b1, 2);
        run(1'b1, 1'b0, 20);
        check("pulse_rise_cnt0", rise_cnt[0], 1);
        check("pulse_fall_cnt0", fall_cnt[0], 1);
        check("pulse_rise_cnt1", rise_cnt[1], 0);

        // Long level: a single rising pulse.
        clr_cnt();
        run(1'b1, 1'b1, 20);
        run(1'b1, 1'b0, 20);
        for (int i = 0; i < NDut; i++) begin
            check($sformatf("long_rise_cnt%0d", i), rise_cnt[i], 1);
            check($sformatf("long_fall_cnt%0d", i), fall_cnt[i], 1);
        end

        // Two 2-cycle pulses 50 cycles apart.
        clr_cnt();
        run(1'b1, 1'b1, 2);
        run(1'b1, 1'b0, 48);
        run(1'b1, 1'b1, 2);
        run(1'b1, 1'b0, 30);
        check("two_rise_cnt0", rise_cnt[0], 2);
        if (rise_cyc[0].size() == 2)
            check("two_spacing0", rise_cyc[0][1] - rise_cyc[0][0], 50);

        // Glitches of 1 and 2 cycles must not pass FILTER_LEN=3.
        clr_cnt();
        run(1'b1, 1'b1, 1);
        run(1'b1, 1'b0, 6);
        run(1'b1, 1'b1, 2);
        run(1'b1, 1'b0, 10);
        check("glitch_rise_cnt1", rise_cnt[1], 0);
        check("glitch_fall_cnt1", fall_cnt[1], 0);
        check("glitch_rise_cnt0", rise_cnt[0], 2);

        // A 3-cycle pulse qualifies for FILTER_LEN=3 but not FILTER_LEN=5.
        clr_cnt();
        run(1'b1, 1'b1, 3);
        run(1'b1, 1'b0, 12);
        check("qual_rise_cnt1", rise_cnt[1], 1);
        check("qual_fall_cnt1", fall_cnt[1], 1);
        check("qual_rise_cnt2", rise_cnt[2], 0);

        // Reset while the level is high; release with the input still high.
        run(1'b1, 1'b1, 12);
        clr_cnt();
        run(1'b0, 1'b1, 2);
        check("rst_level0", {31'b0, lvl[0]}, 0);
        run(1'b1, 1'b1, 12);
        run(1'b1, 1'b0, 12);
        for (int i = 0; i < NDut; i++)
            check($sformatf("rst_rise_cnt%0d", i), rise_cnt[i], 1);

        // Random runs of varying length with occasional resets.
        din = 1'b0;
        for (int r = 0; r < 600; r++) begin
            if ($urandom_range(0, 40) == 0) begin
                run(1'b0, din, $urandom_range(1, 3));
            end else begin
                din = ~din;
                gap = $urandom_range(1, 8);
                run(1'b1, din, gap);
            end
        end
        run(1'b1, 1'b0, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_signal_pulse.md
Name: sync_signal_pulse

Overview:
- Single-clock input conditioner for one asynchronous 1-bit control signal, such as a start or trigger strobe from another clock domain or a pad.
- Passes the signal through a multi-flop synchronizer, then an optional consecutive-sample glitch filter.
- Produces a clean level plus one-cycle rise and fall pulses in the clk domain.
- Sits at the boundary of the SNN core, in front of any logic that consumes external strobes.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- FILTER_LEN, 1, consecutive identical synchronized samples required before signal_level changes; 1 disables filtering; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- signal_in  input  1  asynchronous input; no timing relation to clk.
- signal_level  output  1  synchronized, filtered level of signal_in.
- signal_out  output  1  one-cycle pulse on each rising edge of signal_level.
- fall_out  output  1  one-cycle pulse on each falling edge of signal_level.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: while rst_n=0 at a clk rising edge, the following clear to 0: all synchronizer flops, the filter counter, signal_level, signal_out and fall_out. Reset has priority over all other updates.
- Synchronizer: sync[0] <= signal_in; sync[i] <= sync[i-1]. Only sync[SYNC_STAGES-1] (s) feeds downstream logic. No combinational path from signal_in to any output.
- Filter counter: width max(1, clog2(FILTER_LEN)).
  - If s == signal_level: counter <= 0.
  - Else if counter == FILTER_LEN-1: signal_level <= s and counter <= 0.
  - Else: counter increments.
- Pulses:
  - signal_out is registered. It is 1 for exactly the cycle in which signal_level first reads 1 after being 0.
  - fall_out is the mirror for the 1->0 transition.
  - signal_out and fall_out are never 1 together. Each pulse lasts exactly one cycle, independent of how long signal_in stays high.
- Latency: if signal_in is first sampled high at edge k, signal_level and signal_out rise after edge k+SYNC_STAGES+FILTER_LEN-1. For defaults this is k+2. Falling edges have the same latency.
- Capture guarantee:
  - signal_in pulses must span at least one clk period plus flop setup/hold to be guaranteed captured.
  - Shorter pulses may be captured or dropped, but never yield more than one signal_out pulse.
- Glitches: with FILTER_LEN=N, any excursion of s shorter than N cycles leaves signal_level, signal_out and fall_out unchanged.
- Back-to-back input pulses:
  - Two high periods separated by at least FILTER_LEN low samples at s give two signal_out pulses.
  - Otherwise they merge into one.
- Reset mid-operation: outputs read 0 after the first reset edge, and any in-flight pulse is lost. If signal_in is high at release, signal_level rises with the normal latency and one signal_out pulse occurs.
- Metastability: sync[0] may go metastable. The design relies on the SYNC_STAGES chain; no logic other than sync[1] reads sync[0].

Test Plan:
- Defaults, clk period 10 ns:
  - Stimulus: release reset; after 10 cycles drive signal_in=1 for 2 cycles, then 0.
  - Response: signal_out=1 for exactly one cycle, 2 edges after capture. signal_level high for 2 cycles. fall_out pulses once, 2 cycles after the input falls.
- Defaults, long level:
  - Stimulus: hold signal_in=1 for 20 cycles.
  - Response: a single signal_out pulse; signal_level high 20 cycles; no further pulses.
- Defaults, two pulses:
  - Stimulus: two 2-cycle pulses 50 cycles apart.
  - Response: exactly two signal_out pulses, 50 cycles apart.
- FILTER_LEN=3, glitch rejection:
  - Stimulus: 1-cycle and 2-cycle high glitches.
  - Response: no output activity.
- FILTER_LEN=3, qualifying pulse:
  - Stimulus: a 3-cycle pulse.
  - Response: signal_out at capture+4.
- Reset mid-operation:
  - Stimulus: drop rst_n while signal_level=1.
  - Response: all outputs 0 after the next edge. On release with signal_in=1, signal_out pulses once, 2 edges later.
